// File: rtl/lc3_decode_stage.sv
// LC-3 Decode stage: registers the fetched instruction and its next-PC and
// decodes the Execute / Memory / Writeback control words on the same edge.
module lc3_decode_stage #(
  parameter logic [15:0] RESET_IR  = 16'h0000,
  parameter logic [15:0] RESET_NPC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_control,
  output logic [1:0]  W_control,
  output logic        Mem_control
);

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_NOT = 2'b10
  } alu_t;

  typedef enum logic [1:0] {
    PCS1_OFF11 = 2'b00,
    PCS1_OFF9  = 2'b01,
    PCS1_OFF6  = 2'b10,
    PCS1_ZERO  = 2'b11
  } pcs1_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_PC  = 2'b01,
    WB_MEM = 2'b10
  } wsel_t;

  opcode_t op;
  alu_t    alu;
  pcs1_t   pcs1;
  logic    pcs2;
  logic    op2;
  wsel_t   wsel;
  logic    mem_ind;

  assign op = opcode_t'(dout[15:12]);

  // Decode looks at the incoming word so controls land with the same IR.
  always_comb begin
    alu     = ALU_ADD;
    pcs1    = PCS1_OFF11;
    pcs2    = 1'b0;
    op2     = 1'b0;
    wsel    = WB_ALU;
    mem_ind = 1'b0;
    case (op)
      OP_ADD: op2 = ~dout[5];
      OP_AND: begin
        alu = ALU_AND;
        op2 = ~dout[5];
      end
      OP_NOT: begin
        alu = ALU_NOT;
        op2 = 1'b1;
      end
      OP_BR, OP_ST: begin
        pcs1 = PCS1_OFF9;
        pcs2 = 1'b1;
      end
      OP_JMP: pcs1 = PCS1_ZERO;
      OP_LD: begin
        pcs1 = PCS1_OFF9;
        pcs2 = 1'b1;
        wsel = WB_MEM;
      end
      OP_LDR: begin
        pcs1 = PCS1_OFF6;
        wsel = WB_MEM;
      end
      OP_LDI: begin
        pcs1    = PCS1_OFF9;
        pcs2    = 1'b1;
        wsel    = WB_MEM;
        mem_ind = 1'b1;
      end
      OP_LEA: begin
        pcs1 = PCS1_OFF9;
        pcs2 = 1'b1;
        wsel = WB_PC;
      end
      OP_STR: pcs1 = PCS1_OFF6;
      OP_STI: begin
        pcs1    = PCS1_OFF9;
        pcs2    = 1'b1;
        mem_ind = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      IR          <= RESET_IR;
      npc_out     <= RESET_NPC;
      E_control   <= '0;
      W_control   <= '0;
      Mem_control <= 1'b0;
    end else if (enable_decode) begin
      IR          <= dout;
      npc_out     <= npc_in;
      E_control   <= {alu, pcs1, pcs2, op2};
      W_control   <= wsel;
      Mem_control <= mem_ind;
    end
  end

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Self-checking bench for lc3_decode_stage: table-driven reference model
// compared every cycle, plus hand-computed expectations at key points.
module tb_lc3_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b1;
  logic [15:0] dout = 16'h1283;
  logic [15:0] npc_in = 16'h0000;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        Mem_control;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lc3_decode_stage #(
    .RESET_IR (16'h0000),
    .RESET_NPC(16'h0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .dout         (dout),
    .npc_in       (npc_in),
    .IR           (IR),
    .npc_out      (npc_out),
    .E_control    (E_control),
    .W_control    (W_control),
    .Mem_control  (Mem_control)
  );

  always #5 clock = ~clock;

  // Whole-word E values from the opcode table, register-operand form for ADD/AND.
  logic [5:0] e_tab [16];
  logic [1:0] w_tab [16];
  logic       m_tab [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      e_tab[i] = 6'h00;
      w_tab[i] = 2'd0;
      m_tab[i] = 1'b0;
    end
    e_tab[4'h1] = 6'h01;                                    // ADD
    e_tab[4'h5] = 6'h11;                                    // AND
    e_tab[4'h9] = 6'h21;                                    // NOT
    e_tab[4'h0] = 6'h06;                                    // BR
    e_tab[4'hC] = 6'h0C;                                    // JMP
    e_tab[4'h2] = 6'h06; w_tab[4'h2] = 2'd2;                // LD
    e_tab[4'h6] = 6'h08; w_tab[4'h6] = 2'd2;                // LDR
    e_tab[4'hA] = 6'h06; w_tab[4'hA] = 2'd2; m_tab[4'hA] = 1'b1; // LDI
    e_tab[4'hE] = 6'h06; w_tab[4'hE] = 2'd1;                // LEA
    e_tab[4'h3] = 6'h06;                                    // ST
    e_tab[4'h7] = 6'h08;                                    // STR
    e_tab[4'hB] = 6'h06; m_tab[4'hB] = 1'b1;                // STI
  end

  function automatic logic [5:0] model_e(input logic [15:0] instr);
    logic [5:0] e;
    e = e_tab[instr[15:12]];
    if ((instr[15:12] == 4'h1 || instr[15:12] == 4'h5) && instr[5])
      e = e - 6'd1;
    return e;
  endfunction

  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m;
  logic        m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_ir    <= 16'h0000;
      m_npc   <= 16'h0000;
      m_e     <= 6'h00;
      m_w     <= 2'd0;
      m_m     <= 1'b0;
      m_valid <= 1'b1;
    end else if (enable_decode) begin
      m_ir  <= dout;
      m_npc <= npc_in;
      m_e   <= model_e(dout);
      m_w   <= w_tab[dout[15:12]];
      m_m   <= m_tab[dout[15:12]];
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_ir",  IR,                  m_ir);
      chk("model_npc", npc_out,             m_npc);
      chk("model_e",   {10'd0, E_control},  {10'd0, m_e});
      chk("model_w",   {14'd0, W_control},  {14'd0, m_w});
      chk("model_m",   {15'd0, Mem_control}, {15'd0, m_m});
    end
  end

  task automatic cyc(input logic rst, input logic en, input logic [15:0] d, input logic [15:0] n);
    reset         = rst;
    enable_decode = en;
    dout          = d;
    npc_in        = n;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] ir, input logic [15:0] npc,
                            input logic [5:0] e, input logic [1:0] w, input logic m);
    chk({name, "_ir"},  IR,                   ir);
    chk({name, "_npc"}, npc_out,              npc);
    chk({name, "_e"},   {10'd0, E_control},   {10'd0, e});
    chk({name, "_w"},   {14'd0, W_control},   {14'd0, w});
    chk({name, "_m"},   {15'd0, Mem_control}, {15'd0, m});
  endtask

  initial begin
    cyc(1'b1, 1'b1, 16'h1283, 16'h3001);
    expect_out("reset1", 16'h0000, 16'h0000, 6'h00, 2'd0, 1'b0);
    cyc(1'b1, 1'b1, 16'h1283, 16'h3001);
    expect_out("reset2", 16'h0000, 16'h0000, 6'h00, 2'd0, 1'b0);

    cyc(1'b0, 1'b1, 16'h1283, 16'h3001);
    expect_out("add_reg", 16'h1283, 16'h3001, 6'h01, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 16'h1265, 16'h3002);
    expect_out("add_imm", 16'h1265, 16'h3002, 6'h00, 2'd0, 1'b0);

    cyc(1'b0, 1'b1, 16'h5283, 16'h3003);
    expect_out("and_reg", 16'h5283, 16'h3003, 6'h11, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 16'h9E7F, 16'h3004);
    expect_out("not", 16'h9E7F, 16'h3004, 6'h21, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 16'h6284, 16'h3005);
    expect_out("ldr", 16'h6284, 16'h3005, 6'h08, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 16'hE005, 16'h3006);
    expect_out("lea", 16'hE005, 16'h3006, 6'h06, 2'd1, 1'b0);
    cyc(1'b0, 1'b1, 16'hC0C0, 16'h3007);
    expect_out("jmp", 16'hC0C0, 16'h3007, 6'h0C, 2'd0, 1'b0);

    cyc(1'b0, 1'b1, 16'hA001, 16'h3008);
    expect_out("ldi", 16'hA001, 16'h3008, 6'h06, 2'd2, 1'b1);
    cyc(1'b0, 1'b1, 16'hB001, 16'h3009);
    expect_out("sti", 16'hB001, 16'h3009, 6'h06, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 16'hF025, 16'h300A);
    expect_out("trap", 16'hF025, 16'h300A, 6'h00, 2'd0, 1'b0);

    cyc(1'b0, 1'b1, 16'h6284, 16'h300B);
    expect_out("stall_load", 16'h6284, 16'h300B, 6'h08, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 16'h1283, 16'hFFFF);
      expect_out("stall_hold", 16'h6284, 16'h300B, 6'h08, 2'd2, 1'b0);
    end
    cyc(1'b0, 1'b1, 16'h1283, 16'hFFFF);
    expect_out("reenable", 16'h1283, 16'hFFFF, 6'h01, 2'd0, 1'b0);

    cyc(1'b1, 1'b1, 16'hA001, 16'h4000);
    expect_out("reset_mid", 16'h0000, 16'h0000, 6'h00, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 16'hA001, 16'h4000);
    expect_out("after_reset", 16'hA001, 16'h4000, 6'h06, 2'd2, 1'b1);

    // Sweep every opcode in both bit-5 polarities against the model.
    for (int op = 0; op < 16; op++) begin
      for (int b5 = 0; b5 < 2; b5++) begin
        logic [15:0] w;
        w = {op[3:0], 6'b101101, b5[0], 5'b01010};
        cyc(1'b0, 1'b1, w, 16'h5000 + 16'(op * 2 + b5));
        if (op[0] && b5 == 1 && (op == 1 || op == 5))
          chk("imm_form_e", {10'd0, E_control}, (op == 1) ? 16'h0000 : 16'h0010);
      end
    end

    cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
